// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag width, station tags and LSU responder state encoding.
package tomasulo_pkg;

    localparam int TAG_W = 4;

    localparam logic [TAG_W-1:0] TAG_LOAD1  = 4'd5;
    localparam logic [TAG_W-1:0] TAG_LOAD2  = 4'd6;
    localparam logic [TAG_W-1:0] TAG_STORE1 = 4'd7;
    localparam logic [TAG_W-1:0] TAG_STORE2 = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_array.sv
// Word-addressed data memory: synchronous write, combinational read, contents never reset.
module lsu_mem_array #(
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lsu_mem_responder.sv
// Single-outstanding load/store responder with fixed access latency.
// Optional fault checking (misaligned / out-of-range) enabled by LSU_MEM_MISALIGN_CHECK_EN.
module lsu_mem_responder
    import tomasulo_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_is_store,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_is_store,
    output logic [31:0]      resp_data,
    output logic             resp_err
);

    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    lsu_state_t       state, state_next;
    logic [3:0]       cnt;
    logic [TAG_W-1:0] lat_tag;
    logic             lat_is_store;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      lat_wdata;
    logic             accept;
    logic             leave_access;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    assign accept       = req_valid && req_ready;
    assign leave_access = (state == ST_ACCESS) && (cnt == 4'd0);

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt == 4'd0) state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef LSU_MEM_MISALIGN_CHECK_EN
    logic req_fault;
    logic lat_fault;
    logic err_q;

    assign req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != 32'd0);
    assign mem_we    = leave_access && lat_is_store && !lat_fault;
    assign resp_err  = err_q;

    always_ff @(posedge clk) begin
        if (accept) lat_fault <= req_fault;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (leave_access) begin
            err_q <= lat_fault;
        end
    end
`else
    logic unused_addr_bits;
    logic lat_fault;

    // Offset and upper address bits are don't-care: the index wraps.
    assign unused_addr_bits = ^{req_addr[1:0], req_addr >> (IDX_W + 2)};
    assign lat_fault        = 1'b0;
    assign mem_we           = leave_access && lat_is_store;
    assign resp_err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            resp_tag      <= '0;
            resp_is_store <= 1'b0;
            resp_data     <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if ((state == ST_ACCESS) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (leave_access) begin
                resp_tag      <= lat_tag;
                resp_is_store <= lat_is_store;
                resp_data     <= (lat_is_store || lat_fault) ? 32'd0 : mem_rdata;
            end
        end
    end

    // Request payload is captured once at acceptance; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_tag      <= req_tag;
            lat_is_store <= req_is_store;
            lat_idx      <= req_addr[IDX_W+1:2];
            lat_wdata    <= req_wdata;
        end
    end

    lsu_mem_array #(
        .MEM_WORDS(MEM_WORDS),
        .IDX_W    (IDX_W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (lat_idx),
        .wdata(lat_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder: directed scenarios plus randomized traffic vs. a word-array model.
module tb_lsu_mem_responder;

    localparam int MEM_WORDS = 256;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_tag = 4'd0;
    logic        req_is_store = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [3:0]  resp_tag;
    logic        resp_is_store;
    logic [31:0] resp_data;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [MEM_WORDS];

    lsu_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_tag      (req_tag),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_tag     (resp_tag),
        .resp_is_store(resp_is_store),
        .resp_data    (resp_data),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_fault(input logic [31:0] addr);
`ifdef LSU_MEM_MISALIGN_CHECK_EN
        return (addr % 4 != 0) || (addr / 4 >= MEM_WORDS);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request, wait for the response, optionally stall it, then hand it off.
    task automatic run_req(input logic [3:0] tag, input logic st, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall, input string name);
        int          idx;
        bit          flt;
        logic [31:0] exp_data;
        int          n;
        idx      = int'((addr / 4) % MEM_WORDS);
        flt      = addr_fault(addr);
        exp_data = (st || flt) ? 32'd0 : model_mem[idx];

        @(negedge clk);
        chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_tag      = tag;
        req_is_store = st;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_tag      = 4'($urandom);
        req_is_store = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, n, LATENCY);

        for (int i = 0; i < stall; i++) begin
            req_valid    = 1'b1;
            req_is_store = 1'b1;
            req_addr     = 32'($urandom_range(0, 7) * 4);
            @(posedge clk);
            #1;
            chk({name, "_stall_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({name, "_stall_ready"}, {31'd0, req_ready}, 32'd0);
            chk({name, "_stall_tag"}, {28'd0, resp_tag}, {28'd0, tag});
            chk({name, "_stall_data"}, resp_data, exp_data);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        chk({name, "_tag"}, {28'd0, resp_tag}, {28'd0, tag});
        chk({name, "_is_store"}, {31'd0, resp_is_store}, {31'd0, st});
        chk({name, "_data"}, resp_data, exp_data);
        chk({name, "_err"}, {31'd0, resp_err}, {31'd0, flt});
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({name, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({name, "_done_ready"}, {31'd0, req_ready}, 32'd1);
        if (st && !flt) model_mem[idx] = wdata;
    endtask

    initial begin
        logic [31:0] a;
        logic        st;
        // Reset state while asserted and after release.
        #12;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_tag", {28'd0, resp_tag}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Store then load same word, with a stalled load response.
        run_req(4'd7, 1'b1, 32'h10, 32'hDEADBEEF, 0, "st10");
        run_req(4'd5, 1'b0, 32'h10, 32'h0, 0, "ld10");
        run_req(4'd6, 1'b0, 32'h10, 32'h0, 4, "ld10_stall");
        run_req(4'd5, 1'b0, 32'h10, 32'h0, 0, "ld10_again");

        // Reset during ACCESS of an uncommitted store.
        run_req(4'd7, 1'b1, 32'h20, 32'hCAFE0020, 0, "st20");
        @(negedge clk);
        req_valid    = 1'b1;
        req_tag      = 4'd8;
        req_is_store = 1'b1;
        req_addr     = 32'h20;
        req_wdata    = 32'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_resp_tag", {28'd0, resp_tag}, 32'd0);
        chk("abort_resp_store", {31'd0, resp_is_store}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_req(4'd6, 1'b0, 32'h20, 32'h0, 0, "ld20_after_abort");
        chk("ld20_model", model_mem[8], 32'hCAFE0020);

        // Misaligned load and out-of-range store aliasing onto word 0.
        run_req(4'd5, 1'b0, 32'h13, 32'h0, 0, "ld13");
        run_req(4'd7, 1'b1, 32'h0, 32'hA5A5A5A5, 0, "st0");
        run_req(4'd8, 1'b1, 32'h400, 32'h5A5A5A5A, 0, "st400");
        run_req(4'd5, 1'b0, 32'h0, 32'h0, 0, "ld0");
`ifdef LSU_MEM_MISALIGN_CHECK_EN
        chk("word0_kept", model_mem[0], 32'hA5A5A5A5);
`else
        chk("word0_aliased", model_mem[0], 32'h5A5A5A5A);
`endif

        // Populate words 0..7, then random traffic confined to them (with aliases/offsets).
        for (int w = 0; w < 8; w++) run_req(4'd7, 1'b1, 32'(w * 4), $urandom, 0, "fill");
        for (int k = 0; k < 40; k++) begin
            st = 1'($urandom);
            a  = 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'h400 * 32'($urandom_range(1, 5));
            run_req(st ? 4'(7 + $urandom_range(0, 1)) : 4'(5 + $urandom_range(0, 1)),
                    st, a, $urandom, $urandom_range(0, 3), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_responder.md
LSU_MEM_RESPONDER -- requirements
Module: lsu_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, data memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port req_valid  input  1  load/store request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_tag  input  4  issuing station tag (LOAD1=5, LOAD2=6, STORE1=7, STORE2=8).
REQ-008 SHALL have port req_is_store  input  1  1=store, 0=load.
REQ-009 SHALL have port req_addr  input  32  effective byte address.
REQ-010 SHALL have port req_wdata  input  32  store data.
REQ-011 SHALL have port resp_valid  output  1  completion present.
REQ-012 SHALL have port resp_ready  input  1  consumer (CDB side) accepts completion.
REQ-013 SHALL have port resp_tag  output  4  tag of completing request.
REQ-014 SHALL have port resp_is_store  output  1  completion belongs to a store.
REQ-015 SHALL have port resp_data  output  32  load data; 0 for stores.
REQ-016 SHALL have port resp_err  output  1  access fault flag.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-018 SHALL accept a request on a rising edge with req_valid&&req_ready, latching tag, is_store, addr, wdata, and entering ACCESS.
REQ-019 SHALL stay in ACCESS exactly LATENCY cycles (counter loaded LATENCY-1, decrement, exit at 0), so resp_valid first rises LATENCY edges after the acceptance edge.
REQ-020 SHALL commit a store to memory, and capture load data into resp_data, on the edge leaving ACCESS.
REQ-021 SHALL hold resp_tag, resp_is_store, resp_data, resp_err stable while resp_valid=1 and resp_ready=0.
REQ-022 SHALL return to IDLE on the edge with resp_valid&&resp_ready; no same-cycle new acceptance (req_ready stays 0 in RESP).
REQ-023 SHALL index memory by req_addr[log2(MEM_WORDS)+1:2]; upper bits wrap modulo MEM_WORDS unless REQ-029 applies.
REQ-024 SHALL make a load following a store to the same word observe the stored value.
REQ-025 SHALL ignore req_valid outside IDLE; request inputs need not be held after acceptance.

Reset
REQ-026 SHALL, on reset=0, asynchronously force state IDLE, counter 0, req_ready=1 after release, resp_valid=0, resp_tag=0, resp_is_store=0, resp_data=0, resp_err=0.
REQ-027 SHALL abort any in-flight request on reset; an uncommitted store SHALL NOT write memory.
REQ-028 SHALL NOT reset memory array contents.

Configuration
REQ-029 SHALL, with macro LSU_MEM_MISALIGN_CHECK_EN defined, flag addr[1:0]!=0 or word index >= MEM_WORDS as fault: store suppressed, load resp_data=0, resp_err=1, timing unchanged.
REQ-030 SHALL, without LSU_MEM_MISALIGN_CHECK_EN, ignore addr[1:0], wrap per REQ-023, and tie resp_err to 0.

Structure
REQ-031 SHALL take tag width, LOAD1/LOAD2/STORE1/STORE2 constants and the FSM state enum from shared package tomasulo_pkg.
REQ-032 SHALL instantiate sub-module lsu_mem_array (MEM_WORDS x 32, synchronous write, combinational read).

Verification
REQ-033 SHALL cover: store tag 7, addr 0x10, data 0xDEADBEEF, LATENCY=2 -> resp_valid 2 edges after accept, resp_tag=7, resp_is_store=1, resp_data=0.
REQ-034 SHALL cover: then load tag 5, addr 0x10 -> resp_tag=5, resp_data=0xDEADBEEF, resp_err=0.
REQ-035 SHALL cover: resp_ready=0 for 4 cycles during load response -> outputs stable, req_ready=0, second req_valid ignored until handshake.
REQ-036 SHALL cover: reset=0 during ACCESS of store tag 8 to 0x20 (data 0x1234) -> outputs zero, later load 0x20 returns prior value, not 0x1234.
REQ-037 SHALL cover: load addr 0x13 -> with LSU_MEM_MISALIGN_CHECK_EN resp_err=1, resp_data=0; without it, data of word 0x10 and resp_err=0.
REQ-038 SHALL cover: MEM_WORDS=256, store addr 0x400 -> with macro resp_err=1 and word 0 unchanged; without macro word 0 written.
